figure_motion_ctl: RTL and testbench



---
 rtl/figure_pkg.sv | 25 ++
 rtl/frame_tick_gen.sv | 28 ++
 rtl/figure_motion_ctl.sv | 154 +++++++++++++++
 tb/tb_figure_motion_ctl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/figure_pkg.sv
// Shared constants and types for the figure sprite blocks.
// Screen and sprite geometry fix the default movement limits.
package figure_pkg;

    localparam int SPRITE_W     = 26;
    localparam int SPRITE_H     = 26;
    localparam int SPRITE_SCALE = 2;
    localparam int SCREEN_W     = 800;
    localparam int SCREEN_H     = 600;

    // Largest top-left corner that keeps the scaled sprite fully on screen.
    localparam int X_MAX_DEF   = SCREEN_W - SPRITE_SCALE * SPRITE_W;
    localparam int Y_FLOOR_DEF = SCREEN_H - SPRITE_SCALE * SPRITE_H;

    localparam int POS_W   = 12;
    localparam int VEL_W   = 6;
    localparam int ARITH_W = 13;

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } motion_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronises vsync into the pixel clock domain and emits a one-cycle
// pulse per vsync rising edge; shared by every animated figure instance.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic i_vsync,
    output logic o_tick
);

    logic r_vsQ;
    logic r_vsQq;
    logic r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsQ  <= 1'b0;
            r_vsQq <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_vsQ  <= i_vsync;
            r_vsQq <= r_vsQ;
            r_tick <= r_vsQ & ~r_vsQq;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/figure_motion_ctl.sv
// Per-frame sprite position controller: constant-speed horizontal motion
// and a ground/rising/falling jump machine, all stepped on frame_tick.
module figure_motion_ctl
    import figure_pkg::*;
#(
    parameter int X_INIT  = 100,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MIN   = 0,
    parameter int Y_FLOOR = Y_FLOOR_DEF,
    parameter int STEP_X  = 2,
    parameter int JUMP_V0 = 12,
    parameter int GRAVITY = 1,
    parameter int V_MAX   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_jump,
    output logic [POS_W-1:0] rect_posx,
    output logic [POS_W-1:0] rect_posy,
    output logic             on_ground,
    output logic             frame_tick
);

    localparam logic signed [ARITH_W-1:0] C_XMIN   = ARITH_W'(X_MIN);
    localparam logic signed [ARITH_W-1:0] C_XMAX   = ARITH_W'(X_MAX);
    localparam logic signed [ARITH_W-1:0] C_YMIN   = ARITH_W'(Y_MIN);
    localparam logic signed [ARITH_W-1:0] C_YFLOOR = ARITH_W'(Y_FLOOR);
    localparam logic signed [ARITH_W-1:0] C_STEP   = ARITH_W'(STEP_X);
    localparam logic [VEL_W-1:0]          C_V0     = VEL_W'(JUMP_V0);
    localparam logic [VEL_W-1:0]          C_GRAV   = VEL_W'(GRAVITY);
    localparam logic [VEL_W-1:0]          C_VMAX   = VEL_W'(V_MAX);

    logic                      w_tick;
    logic [POS_W-1:0]          r_posX;
    logic [POS_W-1:0]          r_posY;
    logic [VEL_W-1:0]          r_vel;
    motion_state_t             r_state;
    logic                      r_onGround;

    logic signed [ARITH_W-1:0] w_xCur;
    logic signed [ARITH_W-1:0] w_yCur;
    logic signed [ARITH_W-1:0] w_velS;
    logic signed [ARITH_W-1:0] w_xDec;
    logic signed [ARITH_W-1:0] w_xInc;
    logic signed [ARITH_W-1:0] w_yUp;
    logic signed [ARITH_W-1:0] w_nvS;
    logic signed [ARITH_W-1:0] w_yDown;
    logic [VEL_W:0]            w_velSum;
    logic [VEL_W-1:0]          w_velFall;
    logic [VEL_W-1:0]          w_velDec;

    logic [POS_W-1:0]          w_posXNext;
    logic [POS_W-1:0]          w_posYNext;
    logic [VEL_W-1:0]          w_velNext;
    motion_state_t             w_stateNext;

    frame_tick_gen u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_vsync (vsync),
        .o_tick  (w_tick)
    );

    // Widen to signed so underflow below zero is visible before clamping.
    assign w_xCur    = {1'b0, r_posX};
    assign w_yCur    = {1'b0, r_posY};
    assign w_velS    = {{(ARITH_W-VEL_W){1'b0}}, r_vel};
    assign w_xDec    = w_xCur - C_STEP;
    assign w_xInc    = w_xCur + C_STEP;
    assign w_yUp     = w_yCur - w_velS;
    assign w_velDec  = r_vel - C_GRAV;
    assign w_velSum  = {1'b0, r_vel} + {1'b0, C_GRAV};
    assign w_velFall = (w_velSum > {1'b0, C_VMAX}) ? C_VMAX : w_velSum[VEL_W-1:0];
    assign w_nvS     = {{(ARITH_W-VEL_W){1'b0}}, w_velFall};
    assign w_yDown   = w_yCur + w_nvS;

    always_comb begin
        w_posXNext = r_posX;
        if (btn_left && !btn_right) begin
            w_posXNext = (w_xDec < C_XMIN) ? C_XMIN[POS_W-1:0] : w_xDec[POS_W-1:0];
        end else if (btn_right && !btn_left) begin
            w_posXNext = (w_xInc > C_XMAX) ? C_XMAX[POS_W-1:0] : w_xInc[POS_W-1:0];
        end
    end

    always_comb begin
        w_posYNext  = r_posY;
        w_velNext   = r_vel;
        w_stateNext = r_state;
        case (r_state)
            GROUND: begin
                // Take-off tick only loads the speed; y moves from the next tick.
                if (btn_jump) begin
                    w_stateNext = RISING;
                    w_velNext   = C_V0;
                end
            end
            RISING: begin
                if (w_yUp < C_YMIN) begin
                    w_posYNext  = C_YMIN[POS_W-1:0];
                    w_velNext   = '0;
                    w_stateNext = FALLING;
                end else begin
                    w_posYNext = w_yUp[POS_W-1:0];
                    w_velNext  = w_velDec;
                    if (w_velDec == '0) begin
                        w_stateNext = FALLING;
                    end
                end
            end
            FALLING: begin
                if (w_yDown >= C_YFLOOR) begin
                    w_posYNext  = C_YFLOOR[POS_W-1:0];
                    w_velNext   = '0;
                    w_stateNext = GROUND;
                end else begin
                    w_posYNext = w_yDown[POS_W-1:0];
                    w_velNext  = w_velFall;
                end
            end
            default: begin
                w_posYNext  = C_YFLOOR[POS_W-1:0];
                w_velNext   = '0;
                w_stateNext = GROUND;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_posX     <= POS_W'(X_INIT);
            r_posY     <= POS_W'(Y_FLOOR);
            r_vel      <= '0;
            r_state    <= GROUND;
            r_onGround <= 1'b1;
        end else if (w_tick) begin
            r_posX     <= w_posXNext;
            r_posY     <= w_posYNext;
            r_vel      <= w_velNext;
            r_state    <= w_stateNext;
            r_onGround <= (w_stateNext == GROUND);
        end
    end

    assign rect_posx  = r_posX;
    assign rect_posy  = r_posY;
    assign on_ground  = r_onGround;
    assign frame_tick = w_tick;

endmodule

// File: tb/tb_figure_motion_ctl.sv
// Self-checking bench for figure_motion_ctl: a reference model pushes the
// expected position per frame into a queue, drained when the frame update lands.
module tb_figure_motion_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [11:0] posx, posy, cPosx, cPosy;
    logic        onGround, frameTick, cOnGround, cFrameTick;

    typedef struct {
        int x;
        int y;
        int g;
        int cx;
        int cy;
        int cg;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastExp;
    int   nChecks = 0;
    int   nFails  = 0;
    int   mX[2], mY[2], mV[2], mS[2];
    int   mFloor[2] = '{548, 50};

    always #5 clk = ~clk;

    figure_motion_ctl u_dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .rect_posx  (posx),
        .rect_posy  (posy),
        .on_ground  (onGround),
        .frame_tick (frameTick)
    );

    // Low floor so a full jump reaches the ceiling.
    figure_motion_ctl #(.Y_FLOOR(50), .Y_MIN(0)) u_ceil (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .rect_posx  (cPosx),
        .rect_posy  (cPosy),
        .on_ground  (cOnGround),
        .frame_tick (cFrameTick)
    );

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mX[k] = 100;
            mY[k] = mFloor[k];
            mV[k] = 0;
            mS[k] = 0;
        end
        lastExp = '{100, 548, 1, 100, 50, 1};
    endtask

    task automatic modelStep(input logic l, input logic r, input logic j);
        int nv;
        for (int k = 0; k < 2; k++) begin
            if (l && !r) begin
                mX[k] = mX[k] - 2;
                if (mX[k] < 0) mX[k] = 0;
            end else if (r && !l) begin
                mX[k] = mX[k] + 2;
                if (mX[k] > 748) mX[k] = 748;
            end
            case (mS[k])
                0: if (j) begin
                    mS[k] = 1;
                    mV[k] = 12;
                end
                1: if (mY[k] - mV[k] < 0) begin
                    mY[k] = 0;
                    mV[k] = 0;
                    mS[k] = 2;
                end else begin
                    mY[k] = mY[k] - mV[k];
                    mV[k] = mV[k] - 1;
                    if (mV[k] == 0) mS[k] = 2;
                end
                default: begin
                    nv = (mV[k] + 1 > 12) ? 12 : mV[k] + 1;
                    if (mY[k] + nv >= mFloor[k]) begin
                        mY[k] = mFloor[k];
                        mV[k] = 0;
                        mS[k] = 0;
                    end else begin
                        mY[k] = mY[k] + nv;
                        mV[k] = nv;
                    end
                end
            endcase
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e = '{mX[0], mY[0], int'(mS[0] == 0), mX[1], mY[1], int'(mS[1] == 0)};
        sbQ.push_back(e);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        vsync = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_jump = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        sbQ.delete();
        repeat (2) @(negedge clk);
    endtask

    // One video frame: raise vsync with the given buttons, wait for the tick,
    // then drain the scoreboard entry once the update edge has passed.
    task automatic applyStimulus(input logic l, input logic r, input logic j, output int tickEdges);
        exp_t        e;
        bit          found;
        logic [11:0] actV[6];
        int          expV[6];
        string       nm[6] = '{"posx", "posy", "on_ground", "ceil_posx", "ceil_posy", "ceil_on_ground"};
        @(negedge clk);
        btn_left = l;
        btn_right = r;
        btn_jump = j;
        vsync = 1'b1;
        modelStep(l, r, j);
        pushExpected();
        found = 1'b0;
        tickEdges = 0;
        while (!found && tickEdges < 8) begin
            @(posedge clk);
            #1;
            tickEdges++;
            if (frameTick === 1'b1) found = 1'b1;
        end
        nChecks++;
        if (!found) begin
            $display("[TB] FAIL tick_timeout: got no frame_tick within %0d edges, required one", tickEdges);
            nFails++;
        end else begin
            nChecks++;
            if (posx !== 12'(lastExp.x) || posy !== 12'(lastExp.y)) begin
                $display("[TB] FAIL hold_before_update: got %0d/%0d required %0d/%0d", posx, posy, lastExp.x, lastExp.y);
                nFails++;
            end
            @(posedge clk);
            #1;
            nChecks++;
            if (frameTick !== 1'b0) begin
                $display("[TB] FAIL tick_width: got frame_tick=%b required 0", frameTick);
                nFails++;
            end
        end
        e = sbQ.pop_front();
        actV = '{posx, posy, {11'b0, onGround}, cPosx, cPosy, {11'b0, cOnGround}};
        expV = '{e.x, e.y, e.g, e.cx, e.cy, e.cg};
        for (int k = 0; k < 6; k++) begin
            nChecks++;
            if (actV[k] !== 12'(expV[k])) begin
                $display("[TB] FAIL %s: got %0d required %0d", nm[k], actV[k], expV[k]);
                nFails++;
            end
        end
        lastExp = e;
        @(negedge clk);
        vsync = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_jump = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++;
        if (posx !== 12'(e.x) || posy !== 12'(e.y)) begin
            $display("[TB] FAIL hold_between: got %0d/%0d required %0d/%0d", posx, posy, e.x, e.y);
            nFails++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vsync = ~vsync;
            @(posedge clk);
            #1;
            nChecks++;
            if (posx !== 12'd100 || posy !== 12'd548 || onGround !== 1'b1 || frameTick !== 1'b0) begin
                $display("[TB] FAIL reset_values: got x=%0d y=%0d g=%b t=%b required 100/548/1/0", posx, posy, onGround, frameTick);
                nFails++;
            end
            @(negedge clk);
        end
        vsync = 1'b0;
        rst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tick_timing();
        int edges;
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, edges);
        nChecks++;
        if (edges !== 2 || posx !== 12'd102) begin
            $display("[TB] FAIL tick_latency: got edges=%0d x=%0d required 2/102", edges, posx);
            nFails++;
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, edges);
        nChecks++;
        if (posx !== 12'd122) begin
            $display("[TB] FAIL right_10: got %0d required 122", posx);
            nFails++;
        end
        applyStimulus(1'b1, 1'b1, 1'b0, edges);
        nChecks++;
        if (posx !== 12'd122) begin
            $display("[TB] FAIL both_buttons: got %0d required 122", posx);
            nFails++;
        end
    endtask

    task automatic test_vsync_held();
        exp_t e;
        int   ticks = 0;
        resetDut();
        @(negedge clk);
        vsync = 1'b1;
        btn_right = 1'b1;
        modelStep(1'b0, 1'b1, 1'b0);
        pushExpected();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (frameTick === 1'b1) ticks++;
        end
        e = sbQ.pop_front();
        nChecks++;
        if (ticks !== 1 || posx !== 12'(e.x)) begin
            $display("[TB] FAIL vsync_held: got ticks=%0d x=%0d required 1/%0d", ticks, posx, e.x);
            nFails++;
        end
        lastExp = e;
        @(negedge clk);
        vsync = 1'b0;
        btn_right = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ignore_between_ticks();
        int edges;
        @(negedge clk);
        btn_left = 1'b1;
        btn_jump = 1'b1;
        repeat (2) @(negedge clk);
        btn_left = 1'b0;
        btn_jump = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, edges);
        nChecks++;
        if (posx !== 12'd102 || onGround !== 1'b1) begin
            $display("[TB] FAIL ignore_pulses: got x=%0d g=%b required 102/1", posx, onGround);
            nFails++;
        end
    endtask

    task automatic test_clamp();
        int edges;
        resetDut();
        for (int i = 1; i <= 60; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, edges);
            if (i == 50) begin
                nChecks++;
                if (posx !== 12'd0) begin
                    $display("[TB] FAIL left_50: got %0d required 0", posx);
                    nFails++;
                end
            end
        end
        nChecks++;
        if (posx !== 12'd0) begin
            $display("[TB] FAIL left_clamp: got %0d required 0", posx);
            nFails++;
        end
        resetDut();
        for (int i = 0; i < 330; i++) applyStimulus(1'b0, 1'b1, 1'b0, edges);
        nChecks++;
        if (posx !== 12'd748) begin
            $display("[TB] FAIL right_clamp: got %0d required 748", posx);
            nFails++;
        end
    endtask

    task automatic test_full_jump();
        int edges;
        resetDut();
        for (int t = 1; t <= 25; t++) begin
            applyStimulus(1'b0, 1'b0, (t == 1), edges);
            if (t == 1) begin
                nChecks++;
                if (posy !== 12'd548 || onGround !== 1'b0) begin
                    $display("[TB] FAIL jump_tick1: got y=%0d g=%b required 548/0", posy, onGround);
                    nFails++;
                end
            end
            if (t == 13) begin
                nChecks++;
                if (posy !== 12'd470) begin
                    $display("[TB] FAIL jump_apex: got %0d required 470", posy);
                    nFails++;
                end
            end
            if (t == 7) begin
                nChecks++;
                if (cPosy !== 12'd0 || cOnGround !== 1'b0) begin
                    $display("[TB] FAIL ceiling_clamp: got y=%0d g=%b required 0/0", cPosy, cOnGround);
                    nFails++;
                end
            end
            if (t == 17) begin
                nChecks++;
                if (cPosy !== 12'd50 || cOnGround !== 1'b1) begin
                    $display("[TB] FAIL ceiling_land: got y=%0d g=%b required 50/1", cPosy, cOnGround);
                    nFails++;
                end
            end
            if (t == 24) begin
                nChecks++;
                if (onGround !== 1'b0) begin
                    $display("[TB] FAIL jump_airborne24: got g=%b required 0", onGround);
                    nFails++;
                end
            end
        end
        nChecks++;
        if (posy !== 12'd548 || onGround !== 1'b1) begin
            $display("[TB] FAIL jump_land: got y=%0d g=%b required 548/1", posy, onGround);
            nFails++;
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        resetDut();
        for (int t = 1; t <= 26; t++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, edges);
            if (t == 25) begin
                nChecks++;
                if (onGround !== 1'b1 || posy !== 12'd548) begin
                    $display("[TB] FAIL held_land: got y=%0d g=%b required 548/1", posy, onGround);
                    nFails++;
                end
            end
        end
        nChecks++;
        if (onGround !== 1'b0 || posy !== 12'd548) begin
            $display("[TB] FAIL held_rejump: got y=%0d g=%b required 548/0", posy, onGround);
            nFails++;
        end
    endtask

    task automatic test_mid_jump_reset();
        int edges;
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b1, edges);
        for (int t = 2; t <= 5; t++) applyStimulus(1'b0, 1'b1, 1'b0, edges);
        nChecks++;
        if (posy !== 12'd506 || onGround !== 1'b0) begin
            $display("[TB] FAIL pre_reset_rise: got y=%0d g=%b required 506/0", posy, onGround);
            nFails++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        nChecks++;
        if (posy !== 12'd548 || posx !== 12'd100 || onGround !== 1'b1 || cPosy !== 12'd50) begin
            $display("[TB] FAIL mid_jump_reset: got x=%0d y=%0d g=%b cy=%0d required 100/548/1/50", posx, posy, onGround, cPosy);
            nFails++;
        end
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        sbQ.delete();
        repeat (2) @(negedge clk);
        for (int t = 0; t < 3; t++) applyStimulus(1'b0, 1'b0, 1'b0, edges);
        nChecks++;
        if (posy !== 12'd548 || onGround !== 1'b1) begin
            $display("[TB] FAIL no_residual_motion: got y=%0d g=%b required 548/1", posy, onGround);
            nFails++;
        end
    endtask

    initial begin
        $display("[TB] figure_motion_ctl bench start");
        test_reset();
        test_tick_timing();
        test_vsync_held();
        test_ignore_between_ticks();
        test_clamp();
        test_full_jump();
        test_back_to_back();
        test_mid_jump_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
